mux2_arbiter: RTL and testbench

MUX2_ARBITER -- requirements
Module: mux2_arbiter

---
 rtl/mux2_arb_pkg.sv | 15 +
 rtl/mux2_arb_holdcnt.sv | 42 ++++
 rtl/mux2_arbiter.sv | 117 +++++++++++
 tb/tb_mux2_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mux2_arb_pkg.sv
// mux2_arb_pkg: shared definitions for the two-requester arbiter.
//   state_e      : arbiter FSM states (IDLE, GNT_A, GNT_B)
//   OWN_A, OWN_B : owner encoding used by the last-owner register
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_A = 2'b01,
        GNT_B = 2'b10
    } state_e;

    localparam logic OWN_A = 1'b1;
    localparam logic OWN_B = 1'b0;

endpackage

// File: rtl/mux2_arb_holdcnt.sv
// mux2_arb_holdcnt: saturating hold counter for the arbiter timeout.
// Only instantiated when MUX2_ARB_TIMEOUT_EN is defined.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the count at 0 (grant owner changes)
//   en       : count this cycle (a grant is held)
//   timeout  : count has reached HOLD_MAX-1
module mux2_arb_holdcnt #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int unsigned CW = $clog2(HOLD_MAX);
    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX - 1);

    logic [CW-1:0] hold_cnt_q;
    logic [CW-1:0] hold_cnt_d;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (clr) begin
            hold_cnt_d = '0;
        end else if (en && (hold_cnt_q != CNT_MAX)) begin
            hold_cnt_d = hold_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign timeout = (hold_cnt_q == CNT_MAX);

endmodule

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: two-requester arbiter driving a shared output mux.
// Optional macro MUX2_ARB_TIMEOUT_EN enables forced handover after
// HOLD_MAX consecutive grant cycles when the other side is waiting.
//   clk, rst          : clock, synchronous active-high reset
//   req_a, req_b      : requests
//   data_a, data_b    : requester payloads (DW bits)
//   gnt_a, gnt_b      : registered grants (never both 1)
//   sel               : registered mux select (1 = A, 0 = B)
//   out_data          : sel ? data_a : data_b
//   out_valid         : gnt_a | gnt_b
module mux2_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int unsigned DW       = 4,
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          req_b,
    input  logic [DW-1:0] data_a,
    input  logic [DW-1:0] data_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          sel,
    output logic [DW-1:0] out_data,
    output logic          out_valid
);

    state_e state_q, state_d;
    logic   gnt_a_q, gnt_a_d;
    logic   gnt_b_q, gnt_b_d;
    logic   sel_q, sel_d;
    logic   last_owner_q, last_owner_d;
    logic   timeout;

`ifdef MUX2_ARB_TIMEOUT_EN
    mux2_arb_holdcnt #(
        .HOLD_MAX (HOLD_MAX)
    ) u_holdcnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_d != state_q),
        .en      (state_q != IDLE),
        .timeout (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_a && req_b) begin
                    state_d = (last_owner_q == OWN_A) ? GNT_B : GNT_A;
                end else if (req_a) begin
                    state_d = GNT_A;
                end else if (req_b) begin
                    state_d = GNT_B;
                end
            end
            // Owner dropping its request takes priority; the timeout only
            // applies while the owner is still requesting.
            GNT_A: begin
                if (!req_a) begin
                    state_d = req_b ? GNT_B : IDLE;
                end else if (timeout && req_b) begin
                    state_d = GNT_B;
                end
            end
            GNT_B: begin
                if (!req_b) begin
                    state_d = req_a ? GNT_A : IDLE;
                end else if (timeout && req_a) begin
                    state_d = GNT_A;
                end
            end
            default: state_d = IDLE;
        endcase

        gnt_a_d      = (state_d == GNT_A);
        gnt_b_d      = (state_d == GNT_B);
        sel_d        = sel_q;
        last_owner_d = last_owner_q;
        if (state_d == GNT_A) begin
            sel_d        = 1'b1;
            last_owner_d = OWN_A;
        end else if (state_d == GNT_B) begin
            sel_d        = 1'b0;
            last_owner_d = OWN_B;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
            sel_q        <= 1'b0;
            last_owner_q <= OWN_B;
        end else begin
            state_q      <= state_d;
            gnt_a_q      <= gnt_a_d;
            gnt_b_q      <= gnt_b_d;
            sel_q        <= sel_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign gnt_a     = gnt_a_q;
    assign gnt_b     = gnt_b_q;
    assign sel       = sel_q;
    assign out_data  = sel_q ? data_a : data_b;
    assign out_valid = gnt_a_q | gnt_b_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// tb_mux2_arbiter: self-checking bench for mux2_arbiter (DW=4, HOLD_MAX=8).
// Follows MUX2_ARB_TIMEOUT_EN in the same way as the design build.
module tb_mux2_arbiter;

    localparam int unsigned DW   = 4;
    localparam int unsigned HOLD = 8;
`ifdef MUX2_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          req_a, req_b;
    logic [DW-1:0] data_a, data_b;
    logic          gnt_a, gnt_b, sel, out_valid;
    logic [DW-1:0] out_data;

    mux2_arbiter #(
        .DW       (DW),
        .HOLD_MAX (HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .req_b     (req_b),
        .data_a    (data_a),
        .data_b    (data_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: owner 0 = nobody, 1 = A, 2 = B; run counts how many
    // consecutive cycles the current owner has held the output.
    int m_owner = 0;
    int m_last  = 2;
    int m_run   = 0;
    bit m_sel   = 1'b0;

    task automatic model_step();
        int nxt;
        if (rst) begin
            m_owner = 0; m_last = 2; m_run = 0; m_sel = 1'b0;
            return;
        end
        nxt = m_owner;
        if (m_owner == 0) begin
            if (req_a && req_b) nxt = (m_last == 1) ? 2 : 1;
            else if (req_a)     nxt = 1;
            else if (req_b)     nxt = 2;
        end else begin
            bit mine   = (m_owner == 1) ? req_a : req_b;
            bit theirs = (m_owner == 1) ? req_b : req_a;
            int other  = (m_owner == 1) ? 2 : 1;
            if (!mine)                                    nxt = theirs ? other : 0;
            else if (TO_EN && m_run >= int'(HOLD) && theirs) nxt = other;
        end
        if (nxt != 0) begin
            m_run  = (nxt == m_owner) ? m_run + 1 : 1;
            m_last = nxt;
            m_sel  = (nxt == 1);
        end else begin
            m_run = 0;
        end
        m_owner = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic          rst, ra, rb;
        logic [DW-1:0] da, db;
        logic          ga, gb, s, v;
        logic [DW-1:0] od;
    } vec_t;

    vec_t vecs[14];

    initial begin
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; data_a = 4'hA; data_b = 4'h5;

        //            rst   ra    rb    da    db     ga    gb    s     v     od
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'hA, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 4'hA, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 4'hA};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 4'hA, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 4'hA};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 4'hA, 4'h5, 1'b0, 1'b1, 1'b0, 1'b1, 4'h5};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'hA, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 4'hA, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 4'hA};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'hA, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 4'hA};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 4'hA, 4'h5, 1'b0, 1'b1, 1'b0, 1'b1, 4'h5};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 4'hA, 4'h5, 1'b0, 1'b1, 1'b0, 1'b1, 4'h5};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 4'hA, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 4'hA, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 4'hA};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'hA, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 4'hA};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 4'h3, 4'hC, 1'b0, 1'b1, 1'b0, 1'b1, 4'hC};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 4'h3, 4'hC, 1'b1, 1'b0, 1'b1, 1'b1, 4'h3};

        for (int i = 0; i < 14; i++) begin
            rst = vecs[i].rst; req_a = vecs[i].ra; req_b = vecs[i].rb;
            data_a = vecs[i].da; data_b = vecs[i].db;
            tick();
            check($sformatf("vec%0d gnt_a", i), 32'(gnt_a), 32'(vecs[i].ga));
            check($sformatf("vec%0d gnt_b", i), 32'(gnt_b), 32'(vecs[i].gb));
            check($sformatf("vec%0d sel", i), 32'(sel), 32'(vecs[i].s));
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].v));
            check($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].od));
        end

        // Both requesters held: alternation every HOLD cycles with timeout,
        // otherwise A keeps the grant throughout.
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; data_a = 4'hA; data_b = 4'h5;
        tick();
        rst = 1'b0; req_a = 1'b1; req_b = 1'b1;
        for (int i = 0; i < 50; i++) begin
            bit exp_a;
            tick();
            exp_a = TO_EN ? (((i / int'(HOLD)) % 2) == 0) : 1'b1;
            check($sformatf("hold%0d gnt_a", i), 32'(gnt_a), 32'(exp_a));
            check($sformatf("hold%0d gnt_b", i), 32'(gnt_b), 32'(!exp_a));
        end

        // Randomised traffic against the reference model.
        rst = 1'b1;
        tick();
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 29) == 0);
            req_a  = ($urandom_range(0, 3) != 0);
            req_b  = ($urandom_range(0, 3) != 0);
            data_a = DW'($urandom);
            data_b = DW'($urandom);
            tick();
            check($sformatf("rnd%0d gnt_a", i), 32'(gnt_a), 32'(m_owner == 1));
            check($sformatf("rnd%0d gnt_b", i), 32'(gnt_b), 32'(m_owner == 2));
            check($sformatf("rnd%0d sel", i), 32'(sel), 32'(m_sel));
            check($sformatf("rnd%0d out_valid", i), 32'(out_valid), 32'(m_owner != 0));
            check($sformatf("rnd%0d out_data", i), 32'(out_data), 32'(m_sel ? data_a : data_b));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
